wave_capture_scheduler: RTL and testbench

WAVE_CAPTURE_SCHEDULER -- requirements
Module: wave_capture_scheduler

---
 rtl/wave_capture_scheduler.sv | 173 +++++++++++++++++
 tb/tb_wave_capture_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture_scheduler.sv
// Waveform capture scheduler for a double-buffered scope display.
// Round-robins over up to four audio sources, arms on a frame pulse, waits
// for an upward zero crossing (or a sample-count timeout), then streams 256
// samples into the write half of the display RAM. The halves swap only on
// the frame pulse that follows a finished capture.

// Per-source sample decode: sign for crossing detection and the
// offset-binary byte written to the display RAM.
module wave_capture_lane (
    input  logic [15:0] sample,
    output logic        neg,
    output logic [7:0]  code
);
    assign neg  = sample[15];
    assign code = {~sample[15], sample[14:8]};
endmodule

module wave_capture_scheduler #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  src_mask,
    input  logic [63:0] sample_in,
    input  logic [3:0]  sample_valid,
    input  logic        new_frame,
    output logic        write_en,
    output logic [8:0]  write_address,
    output logic [7:0]  write_sample,
    output logic        read_index,
    output logic [1:0]  wave_position,
    output logic [1:0]  state
);
    localparam int NUM_SRC = 4;
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     st;
    logic [1:0] cur_src;
    logic [1:0] rr_ptr;
    logic       write_index;
    logic       prev_neg;
    logic [9:0] tcount;
    logic [7:0] idx;

    logic [NUM_SRC-1:0][15:0] lane_sample;
    logic [NUM_SRC-1:0]       lane_neg;
    logic [NUM_SRC-1:0][7:0]  lane_code;

    assign lane_sample = sample_in;

    genvar k;
    generate
        for (k = 0; k < NUM_SRC; k++) begin : g_lane
            wave_capture_lane u_lane (
                .sample (lane_sample[k]),
                .neg    (lane_neg[k]),
                .code   (lane_code[k])
            );
        end
    endgenerate

    // Only the selected source matters; everything else is ignored.
    logic       cur_valid;
    logic       cur_neg;
    logic [7:0] cur_code;
    logic       keep;
    logic       fire;

    assign cur_valid = sample_valid[cur_src];
    assign cur_neg   = lane_neg[cur_src];
    assign cur_code  = lane_code[cur_src];
    // A capture survives only while enabled and its source stays in the mask.
    assign keep      = enable & src_mask[cur_src];
    // Upward crossing, or the last sample the timeout allows.
    assign fire      = (prev_neg & ~cur_neg) | (tcount == TMO_LAST);

    assign state      = st;
    assign read_index = ~write_index;

    // First enabled source at or after ptr, wrapping 3->0. Scanning from the
    // far end lets the nearest hit overwrite the rest.
    function automatic logic [1:0] pick_src(input logic [1:0] ptr,
                                            input logic [3:0] mask);
        logic [1:0] sel;
        sel = ptr;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (mask[ptr + 2'(i)]) sel = ptr + 2'(i);
        end
        return sel;
    endfunction

    // Capture FSM with registered RAM write port and buffer bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st            <= IDLE;
            cur_src       <= 2'd0;
            rr_ptr        <= 2'd0;
            write_index   <= 1'b0;
            wave_position <= 2'd0;
            prev_neg      <= 1'b0;
            tcount        <= 10'd0;
            idx           <= 8'd0;
            write_en      <= 1'b0;
            write_address <= 9'd0;
            write_sample  <= 8'd0;
        end else begin
            write_en <= 1'b0;
            case (st)
                IDLE: begin
                    if (new_frame && enable && (src_mask != 4'd0)) begin
                        cur_src  <= pick_src(rr_ptr, src_mask);
                        prev_neg <= 1'b0;
                        tcount   <= 10'd0;
                        st       <= ARMED;
                    end
                end
                ARMED: begin
                    if (!keep) begin
                        st <= IDLE;
                    end else if (cur_valid) begin
                        if (fire) begin
                            write_en      <= 1'b1;
                            write_address <= {write_index, 8'd0};
                            write_sample  <= cur_code;
                            idx           <= 8'd1;
                            st            <= ACTIVE;
                        end else begin
                            prev_neg <= cur_neg;
                            tcount   <= tcount + 10'd1;
                        end
                    end
                end
                ACTIVE: begin
                    if (!keep) begin
                        // Partial half stays the write half; no flip.
                        st <= IDLE;
                    end else if (cur_valid) begin
                        write_en      <= 1'b1;
                        write_address <= {write_index, idx};
                        write_sample  <= cur_code;
                        idx           <= idx + 8'd1;
                        if (idx == 8'hFF) st <= DONE;
                    end
                end
                DONE: begin
                    if (!keep) begin
                        st <= IDLE;
                    end else if (new_frame) begin
                        // keep guarantees enable=1 and a non-empty mask, so
                        // the reselection always re-arms. Samples this cycle
                        // are dropped since nothing is armed yet.
                        write_index   <= ~write_index;
                        wave_position <= cur_src;
                        rr_ptr        <= cur_src + 2'd1;
                        cur_src       <= pick_src(cur_src + 2'd1, src_mask);
                        prev_neg      <= 1'b0;
                        tcount        <= 10'd0;
                        st            <= ARMED;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_capture_scheduler.sv
// Randomized bench for wave_capture_scheduler against a behavioural
// capture-level reference model.
module tb_wave_capture_scheduler;
    localparam int TMO = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  src_mask = 4'd0;
    logic [63:0] sample_in = 64'd0;
    logic [3:0]  sample_valid = 4'd0;
    logic        new_frame = 1'b0;
    logic        write_en;
    logic [8:0]  write_address;
    logic [7:0]  write_sample;
    logic        read_index;
    logic [1:0]  wave_position;
    logic [1:0]  state;

    wave_capture_scheduler #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .src_mask      (src_mask),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .new_frame     (new_frame),
        .write_en      (write_en),
        .write_address (write_address),
        .write_sample  (write_sample),
        .read_index    (read_index),
        .wave_position (wave_position),
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Reference model: the capture described as "which source, how many
    // samples seen, which half is being filled".
    int m_st, m_src, m_ptr, m_widx, m_wpos, m_pn, m_cnt, m_idx;
    int exp_we, exp_addr, exp_dat;

    // Stimulus waveforms: sawtooth per source, or a DC level.
    int ph[4];
    int stepv[4];
    bit dc[4];

    function automatic int pick(input int ptr, input logic [3:0] mask);
        for (int i = 0; i < 4; i++)
            if (mask[(ptr + i) % 4]) return (ptr + i) % 4;
        return ptr;
    endfunction

    function automatic void mdl_reset();
        m_st = 0; m_src = 0; m_ptr = 0; m_widx = 0; m_wpos = 0;
        m_pn = 0; m_cnt = 0; m_idx = 0; exp_we = 0; exp_addr = 0; exp_dat = 0;
    endfunction

    function automatic void mdl_write(input int i, input logic [15:0] s);
        exp_we   = 1;
        exp_addr = m_widx * 256 + i;
        exp_dat  = (int'($signed(s)) + 32768) / 256;
    endfunction

    function automatic void mdl_arm(input int ptr);
        m_src = pick(ptr, src_mask);
        m_pn  = 0;
        m_cnt = 0;
        m_st  = 1;
    endfunction

    // One clock of behaviour, from the inputs as they stand before the edge.
    function automatic void mdl_step();
        logic [15:0] s;
        exp_we = 0;
        s = sample_in[16*m_src +: 16];
        if (m_st == 0) begin
            if (new_frame && enable && src_mask != 0) mdl_arm(m_ptr);
        end else if (!enable || !src_mask[m_src]) begin
            m_st = 0;
        end else if (m_st == 1) begin
            if (sample_valid[m_src]) begin
                m_cnt++;
                if ((m_pn && !s[15]) || m_cnt == TMO) begin
                    mdl_write(0, s);
                    m_idx = 1;
                    m_st = 2;
                end else begin
                    m_pn = s[15];
                end
            end
        end else if (m_st == 2) begin
            if (sample_valid[m_src]) begin
                mdl_write(m_idx, s);
                if (m_idx == 255) m_st = 3;
                m_idx++;
            end
        end else begin
            if (new_frame) begin
                m_widx = 1 - m_widx;
                m_wpos = m_src;
                m_ptr  = (m_src + 1) % 4;
                mdl_arm(m_ptr);
            end
        end
    endfunction

    // Drive one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input bit nf, input bit en, input logic [3:0] mask,
                        input logic [3:0] vld);
        @(negedge clk);
        new_frame = nf; enable = en; src_mask = mask; sample_valid = vld;
        for (int k = 0; k < 4; k++) begin
            sample_in[16*k +: 16] = dc[k] ? 16'h4000 : 16'(ph[k] * stepv[k]);
            if (vld[k]) ph[k]++;
        end
        mdl_step();
        @(posedge clk);
        #1;
        chk("state", 32'(state), 32'(m_st));
        chk("write_en", 32'(write_en), 32'(exp_we));
        if (exp_we != 0) begin
            chk("write_address", 32'(write_address), 32'(exp_addr));
            chk("write_sample", 32'(write_sample), 32'(exp_dat));
        end
        chk("read_index", 32'(read_index), 32'(1 - m_widx));
        chk("wave_position", 32'(wave_position), 32'(m_wpos));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_we"}, 32'(write_en), 0);
        chk({tag, "_addr"}, 32'(write_address), 0);
        chk({tag, "_data"}, 32'(write_sample), 0);
        chk({tag, "_rd_idx"}, 32'(read_index), 1);
        chk({tag, "_wpos"}, 32'(wave_position), 0);
    endtask

    function automatic logic [3:0] rnd_vld(input logic [3:0] bias);
        logic [3:0] v;
        v = 4'($urandom);
        for (int k = 0; k < 4; k++)
            if (bias[k]) v[k] = ($urandom_range(0, 3) != 0);
        return v;
    endfunction

    initial begin
        int first_we;
        int first_dat;
        logic [3:0] mask;
        for (int k = 0; k < 4; k++) begin
            ph[k] = 0;
            stepv[k] = $urandom_range(300, 2500);
            dc[k] = 1'b0;
        end
        mdl_reset();

        // Asynchronous reset from power-up.
        #2 reset = 1'b0;
        #11;
        chk_reset_vals("por");
        @(negedge clk) reset = 1'b1;

        // Single source: same source every capture, frames at random times.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, 1'b1, 4'b0001, rnd_vld(4'b0001));

        // Round-robin over a sparse mask.
        for (int i = 0; i < 5000; i++)
            step($urandom_range(0, 199) == 0, 1'b1, 4'b1011, rnd_vld(4'b1011));

        // Everything random: enable drops, mask changes, frequent frames.
        mask = 4'b1111;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 299) == 0) mask = 4'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 799) != 0, mask,
                 rnd_vld(4'b1111));
        end

        // DC level on source 2: only the timeout can trigger.
        step(1'b0, 1'b0, 4'b0100, 4'b0000);
        dc[2] = 1'b1;
        first_we = -1;
        first_dat = -1;
        step(1'b1, 1'b1, 4'b0100, 4'b0000);
        for (int i = 1; i < 1100; i++) begin
            step(1'b0, 1'b1, 4'b0100, 4'b0100);
            if (write_en && first_we < 0) begin
                first_we = i;
                first_dat = int'(write_sample);
            end
        end
        chk("dc_trigger_sample", 32'(first_we), 32'(TMO));
        chk("dc_first_data", 32'(first_dat), 32'h0C0);
        dc[2] = 1'b0;

        // Abandon an active capture with an asynchronous reset.
        step(1'b0, 1'b0, 4'b0001, 4'b0000);
        step(1'b1, 1'b1, 4'b0001, 4'b0000);
        for (int i = 0; i < 3000 && !(m_st == 2 && m_idx > 40); i++)
            step(1'b0, 1'b1, 4'b0001, 4'b0001);
        chk("reach_active", 32'(state), 2);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("async");
        mdl_reset();
        @(posedge clk);
        #1;
        chk_reset_vals("held");
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 299) == 0, 1'b1, 4'b0001, rnd_vld(4'b0001));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
